// File: rtl/uart_tx_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_gen_if
// Brief    : Word handshake between the FIFO/register side and uart_tx_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  DATA_READY;

    modport master (
        output P_DATA,
        output DATA_VALID,
        input  DATA_READY
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        output DATA_READY
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_gen
// Brief    : UART transmitter, start/data/parity/stop framing, programmable
//            bit period. UART_TX_HOLD_BUF_EN adds a one-word holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  wire                  CLK,
    input  wire                  RST,
    uart_tx_gen_if.slave         tx_if,
    input  wire                  PAR_EN,
    input  wire                  PAR_TYP,
    input  wire                  STOP2,
    input  wire [DIV_WIDTH-1:0]  DIV,
    output logic                 TX_OUT,
    output logic                 busy
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]            state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_bit_q,  par_bit_d;
    logic                  par_en_q,   par_en_d;
    logic                  stop2_q,    stop2_d;
    logic [DIV_WIDTH-1:0]  div_q,      div_d;
    logic [DIV_WIDTH-1:0]  cnt_q,      cnt_d;
    logic [BIT_W-1:0]      bit_q,      bit_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q,       tx_d;
    logic                  busy_q,     busy_d;
`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_WIDTH-1:0] hold_q,      hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  w_from_hold;
`endif

    logic                  w_xfer;
    logic                  w_tick;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_word;

    assign w_xfer = tx_if.DATA_VALID & tx_if.DATA_READY;
    assign w_tick = (cnt_q == div_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= c_IDLE;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_HOLD_BUF_EN
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_en_d    = par_en_q;
        stop2_d     = stop2_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        stop_cnt_d  = stop_cnt_q;
        w_load      = 1'b0;
        w_load_word = tx_if.P_DATA;
`ifdef UART_TX_HOLD_BUF_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        w_from_hold = 1'b0;
`endif

        if (state_q != c_IDLE) begin
            cnt_d = w_tick ? '0 : cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            c_IDLE: begin
                if (w_xfer) begin
                    w_load = 1'b1;
                end
            end
            c_START: begin
                if (w_tick) begin
                    state_d = c_DATA;
                    bit_d   = '0;
                end
            end
            c_DATA: begin
                if (w_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == c_LAST_BIT) begin
                        state_d    = par_en_q ? c_PARITY : c_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            c_PARITY: begin
                if (w_tick) begin
                    state_d    = c_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            c_STOP: begin
                if (w_tick) begin
                    if (stop_cnt_q == stop2_q) begin
                        state_d = c_IDLE;
`ifdef UART_TX_HOLD_BUF_EN
                        // Chain straight into the next frame with no idle cycle
                        if (hold_full_q) begin
                            w_load      = 1'b1;
                            w_load_word = hold_q;
                            w_from_hold = 1'b1;
                        end else if (w_xfer) begin
                            w_load = 1'b1;
                        end
`endif
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

`ifdef UART_TX_HOLD_BUF_EN
        if (w_from_hold) begin
            hold_full_d = 1'b0;
        end else if (w_xfer && !w_load) begin
            hold_d      = tx_if.P_DATA;
            hold_full_d = 1'b1;
        end
`endif

        // Frame settings are captured here so mid-frame input changes are ignored
        if (w_load) begin
            state_d   = c_START;
            shift_d   = w_load_word;
            par_bit_d = (^w_load_word) ^ PAR_TYP;
            par_en_d  = PAR_EN;
            stop2_d   = STOP2;
            div_d     = DIV;
            cnt_d     = '0;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            c_START:  tx_d = 1'b0;
            c_DATA:   tx_d = shift_d[0];
            c_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != c_IDLE);
`ifdef UART_TX_HOLD_BUF_EN
        tx_if.DATA_READY = ~hold_full_q;
`else
        tx_if.DATA_READY = (state_q == c_IDLE);
`endif
        TX_OUT = tx_q;
        busy   = busy_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_gen
// Brief    : Self-checking bench for uart_tx_gen (8-bit and 7-bit instances)
//            against a frame-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_gen;
    logic       clk = 1'b0;
    logic       RST;
    logic       PAR_EN, PAR_TYP, STOP2;
    logic [7:0] DIV;
    logic       tx8, busy8, tx7, busy7;
    logic       dut_sel;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         exp_tx[$];
    bit         exp_busy[$];

`ifdef UART_TX_HOLD_BUF_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    uart_tx_gen_if #(.DATA_WIDTH(8)) if8 ();
    uart_tx_gen_if #(.DATA_WIDTH(7)) if7 ();

    uart_tx_gen #(.DATA_WIDTH(8), .DIV_WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(RST), .tx_if(if8.slave),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .DIV(DIV),
        .TX_OUT(tx8), .busy(busy8)
    );

    uart_tx_gen #(.DATA_WIDTH(7), .DIV_WIDTH(8)) u_dut7 (
        .CLK(clk), .RST(RST), .tx_if(if7.slave),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .DIV(DIV),
        .TX_OUT(tx7), .busy(busy7)
    );

    wire logic w_tx    = dut_sel ? tx7  : tx8;
    wire logic w_busy  = dut_sel ? busy7 : busy8;
    wire logic w_ready = dut_sel ? if7.DATA_READY : if8.DATA_READY;

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels, one entry per clock, from the frame definition
    task automatic build_frame(input logic [8:0] data, input int width, input bit pe,
                               input bit pt, input bit s2, input int div);
        bit bits[$];
        int ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < width; i++) begin
            bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int r = 0; r <= div; r++) begin
                exp_tx.push_back(bits[i]);
                exp_busy.push_back(1'b1);
            end
        end
    endtask

    task automatic send_frame(input bit sel, input logic [8:0] data, input bit pe, input bit pt,
                              input bit s2, input int div, input int chg_at, input int abort_at,
                              input string tag);
        int guard = 0;
        exp_tx.delete();
        exp_busy.delete();
        build_frame(data, sel ? 7 : 8, pe, pt, s2, div);
        @(negedge clk);
        dut_sel = sel;
        PAR_EN  = pe;
        PAR_TYP = pt;
        STOP2   = s2;
        DIV     = 8'(div);
        if8.P_DATA = data[7:0];
        if7.P_DATA = data[6:0];
        if (sel) if7.DATA_VALID = 1'b1;
        else     if8.DATA_VALID = 1'b1;
        while (!w_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!w_ready) begin
            check({tag, "_ready_timeout"}, 32'(w_ready), 32'd1);
            if8.DATA_VALID = 1'b0;
            if7.DATA_VALID = 1'b0;
            return;
        end
        for (int n = 0; n < exp_tx.size(); n++) begin
            @(negedge clk);
            if (n == 0) begin
                if8.DATA_VALID = 1'b0;
                if7.DATA_VALID = 1'b0;
                check($sformatf("%s_ready_busy", tag), 32'(w_ready), 32'(HOLD));
            end
            check($sformatf("%s_tx%0d", tag, n), 32'(w_tx), 32'(exp_tx[n]));
            check($sformatf("%s_busy%0d", tag, n), 32'(w_busy), 32'(exp_busy[n]));
            if (n == chg_at) begin
                DIV     = 8'd0;
                PAR_EN  = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
                STOP2   = ~STOP2;
            end
            if (n == abort_at) begin
                RST = 1'b1;
                @(negedge clk);
                check({tag, "_abort_tx"}, 32'(w_tx), 32'd1);
                check({tag, "_abort_busy"}, 32'(w_busy), 32'd0);
                RST = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check({tag, "_end_tx"}, 32'(w_tx), 32'd1);
        check({tag, "_end_busy"}, 32'(w_busy), 32'd0);
        check({tag, "_end_ready"}, 32'(w_ready), 32'd1);
    endtask

    task automatic throughput(input logic [7:0] w0, input logic [7:0] w1);
        logic [7:0] words [2];
        int  idx = 0;
        int  guard = 0;
        bit  pending;
        words[0] = w0;
        words[1] = w1;
        exp_tx.delete();
        exp_busy.delete();
        build_frame({1'b0, w0}, 8, 1'b1, 1'b0, 1'b0, 1);
        if (!HOLD) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
        end
        build_frame({1'b0, w1}, 8, 1'b1, 1'b0, 1'b0, 1);
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b0);
        @(negedge clk);
        dut_sel = 1'b0;
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; DIV = 8'd1;
        if8.P_DATA = words[0];
        if8.DATA_VALID = 1'b1;
        while (!w_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        pending = w_ready;
        for (int n = 0; n < exp_tx.size(); n++) begin
            @(negedge clk);
            if (pending) begin
                idx++;
                if (idx < 2) if8.P_DATA = words[idx];
                else         if8.DATA_VALID = 1'b0;
            end
            check($sformatf("thru_tx%0d", n), 32'(w_tx), 32'(exp_tx[n]));
            check($sformatf("thru_busy%0d", n), 32'(w_busy), 32'(exp_busy[n]));
            pending = if8.DATA_VALID && w_ready;
        end
        if8.DATA_VALID = 1'b0;
        check("thru_words_taken", 32'(idx), 32'd2);
    endtask

    initial begin
        RST = 1'b1;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; DIV = 8'd0;
        dut_sel = 1'b0;
        if8.P_DATA = '0; if8.DATA_VALID = 1'b0;
        if7.P_DATA = '0; if7.DATA_VALID = 1'b0;

        // Reset held with a word offered: nothing may start
        @(negedge clk);
        if8.P_DATA = 8'hFF;
        if8.DATA_VALID = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx8), 32'd1);
        check("rst_busy", 32'(busy8), 32'd0);
        RST = 1'b0;
        if8.DATA_VALID = 1'b0;
        @(negedge clk);
        check("rst_rel_tx", 32'(tx8), 32'd1);
        check("rst_rel_busy", 32'(busy8), 32'd0);
        check("rst_rel_ready", 32'(if8.DATA_READY), 32'd1);
        check("rst_rel_ready7", 32'(if7.DATA_READY), 32'd1);

        send_frame(1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0, 0, -1, -1, "even");
        send_frame(1'b0, 9'h001, 1'b1, 1'b1, 1'b1, 3, 6, -1, "odd_slow");
        send_frame(1'b1, 9'h055, 1'b0, 1'b0, 1'b0, 1, -1, -1, "narrow");
        throughput(8'h3C, 8'hC3);
        send_frame(1'b0, 9'({$urandom} & 32'hFF), 1'b0, 1'b0, 1'b0, 0, -1, 5, "abort");
        send_frame(1'b0, 9'h0C6, 1'b1, 1'b0, 1'b1, 0, -1, -1, "post_abort");

        for (int i = 0; i < 24; i++) begin
            send_frame(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), int'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1, -1,
                       $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
